// File: rtl/pwm_meter_pkg.sv
// ============================================================================
// pwm_meter_pkg : shared types and defaults for the PWM duty-cycle meter
// Revision 1.0
// ============================================================================
`default_nettype none

package pwm_meter_pkg;

  localparam int CNT_W_DEF = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } meter_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_in_sync.sv
// ============================================================================
// pwm_in_sync : two-flop synchronizer, optional 3-sample majority filter
//               (PWM_METER_GLITCH_FILTER_EN) and registered edge detector
// Revision 1.0
// ============================================================================
`default_nettype none

module pwm_in_sync (
  input  logic sys_clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic edge_q;
  logic cond;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

`ifdef PWM_METER_GLITCH_FILTER_EN
  logic hist1;
  logic hist2;
  logic filt;

  // Any two of the last three samples agreeing wins, so one-cycle pulses vanish.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      hist1 <= 1'b0;
      hist2 <= 1'b0;
      filt  <= 1'b0;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
      filt  <= (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);
    end
  end

  assign cond = filt;
`else
  assign cond = sync2;
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      edge_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      edge_q <= cond;
      rise   <= cond & ~edge_q;
      fall   <= ~cond & edge_q;
    end
  end

  assign level = edge_q;

endmodule

`default_nettype wire

// File: rtl/pwm_duty_meter.sv
// ============================================================================
// pwm_duty_meter : measures period and high time of an asynchronous PWM input
//                  and flags a stuck input; glitch filter via
//                  PWM_METER_GLITCH_FILTER_EN
// Revision 1.0
// ============================================================================
`default_nettype none

module pwm_duty_meter
  import pwm_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic             level;
  logic             rise;
  logic             fall;
  meter_state_t     state;
  logic [CNT_W-1:0] cnt_per;
  logic [CNT_W-1:0] cnt_hi;

  pwm_in_sync u_sync (
    .sys_clk (sys_clk),
    .rst     (rst),
    .pin     (pwm_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  // cnt_per stops at TO_VAL because reaching it always leaves HIGH/LOW,
  // so the counters can never wrap.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt_per     <= '0;
      cnt_hi      <= '0;
      period      <= '0;
      high_time   <= '0;
      meas_valid  <= 1'b0;
      timeout     <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            cnt_per <= ONE;
            cnt_hi  <= ONE;
            state   <= HIGH;
          end
        end
        HIGH: begin
          if (cnt_per == TO_VAL) begin
            timeout     <= 1'b1;
            stuck_level <= level;
            state       <= IDLE;
          end else begin
            cnt_per <= cnt_per + ONE;
            if (fall) begin
              state <= LOW;
            end else begin
              cnt_hi <= cnt_hi + ONE;
            end
          end
        end
        LOW: begin
          // A rise on the timeout cycle still completes the measurement.
          if (rise) begin
            period     <= cnt_per;
            high_time  <= cnt_hi;
            meas_valid <= 1'b1;
            cnt_per    <= ONE;
            cnt_hi     <= ONE;
            state      <= HIGH;
          end else if (cnt_per == TO_VAL) begin
            timeout     <= 1'b1;
            stuck_level <= level;
            state       <= IDLE;
          end else begin
            cnt_per <= cnt_per + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_meter.sv
// ============================================================================
// tb_pwm_duty_meter : randomized self-checking bench with an edge-time model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pwm_duty_meter;

  localparam int CW = 20;
  localparam int TO = 500;
`ifdef PWM_METER_GLITCH_FILTER_EN
  localparam bit GLITCH_VIS = 1'b0;
  localparam int HMIN = 2;
  localparam int HMAX = 98;
`else
  localparam bit GLITCH_VIS = 1'b1;
  localparam int HMIN = 1;
  localparam int HMAX = 99;
`endif

  typedef struct {
    bit          to;
    logic [CW-1:0] per;
    logic [CW-1:0] hi;
    logic        lvl;
    int          cyc;
  } ev_t;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          pwm_in = 1'b0;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          timeout;
  logic          stuck_level;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int both_cnt = 0;
  ev_t obs_q[$];
  ev_t exp_q[$];

  bit            m_pin = 1'b0;
  bit            m_armed = 1'b0;
  bit            m_fell = 1'b0;
  int            m_t = 0;
  int            m_r0 = 0;
  int            m_f0 = 0;
  logic [CW-1:0] m_per = '0;
  logic [CW-1:0] m_hi = '0;

  pwm_duty_meter #(.CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .period      (period),
    .high_time   (high_time),
    .meas_valid  (meas_valid),
    .timeout     (timeout),
    .stuck_level (stuck_level)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    ev_t e;
    e.cyc = cyc;
    e.per = period;
    e.hi  = high_time;
    if (meas_valid) begin
      e.to = 1'b0; e.lvl = 1'b0; obs_q.push_back(e);
    end
    if (timeout) begin
      e.to = 1'b1; e.lvl = stuck_level; obs_q.push_back(e);
    end
    if (meas_valid && timeout) both_cnt++;
  end

  // Reference: a measurement spans two pin rises with a fall between;
  // no rise within TO cycles of the last one means a stuck input.
  task automatic model_step(input bit p);
    ev_t e;
    e.cyc = 0;
    if (p && !m_pin) begin
      if (m_armed && m_fell) begin
        m_per = CW'(m_t - m_r0);
        m_hi  = CW'(m_f0 - m_r0);
        e.to = 1'b0; e.per = m_per; e.hi = m_hi; e.lvl = 1'b0;
        exp_q.push_back(e);
      end
      m_armed = 1'b1; m_fell = 1'b0; m_r0 = m_t;
    end else if (m_armed && (m_t - m_r0) == TO) begin
      e.to = 1'b1; e.per = m_per; e.hi = m_hi; e.lvl = p;
      exp_q.push_back(e);
      m_armed = 1'b0;
    end else if (!p && m_pin && m_armed && !m_fell) begin
      m_fell = 1'b1; m_f0 = m_t;
    end
    m_pin = p;
    m_t++;
  endtask

  task automatic drive(input bit lvl, input int len, input bit vis = 1'b1);
    for (int n = 0; n < len; n++) begin
      @(negedge sys_clk);
      pwm_in = lvl;
      model_step(vis ? lvl : m_pin);
    end
  endtask

  task automatic model_clear();
    m_pin = 1'b0; m_armed = 1'b0; m_fell = 1'b0; m_per = '0; m_hi = '0;
  endtask

  task automatic reset_dut();
    @(negedge sys_clk);
    rst = 1'b1; pwm_in = 1'b0;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    model_clear();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; pwm_in = 1'b0;
    repeat (4) @(negedge sys_clk);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    n_checks++; if (period !== '0) $display("FAIL reset_period got %0d want 0", period); else n_pass++;
    n_checks++; if (high_time !== '0) $display("FAIL reset_high got %0d want 0", high_time); else n_pass++;
    n_checks++; if (meas_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", meas_valid); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout); else n_pass++;
    n_checks++; if (stuck_level !== 1'b0) $display("FAIL reset_stuck got %b want 0", stuck_level); else n_pass++;
  endtask

  task automatic test_fixed_pwm();
    reset_dut();
    for (int k = 0; k < 6; k++) begin drive(1, 30); drive(0, 70); end
    drive(1, 30); drive(0, 20);
    n_checks++;
    if (obs_q.size() !== 6 || exp_q.size() !== 6)
      $display("FAIL fixed_count got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].to !== exp_q[i].to || obs_q[i].per !== exp_q[i].per || obs_q[i].hi !== exp_q[i].hi)
        $display("FAIL fixed_ev%0d got to=%b per=%0d hi=%0d want to=%b per=%0d hi=%0d", i,
                 obs_q[i].to, obs_q[i].per, obs_q[i].hi, exp_q[i].to, exp_q[i].per, exp_q[i].hi);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (obs_q[i].cyc - obs_q[i-1].cyc != 100)
          $display("FAIL fixed_spacing%0d got %0d want 100", i, obs_q[i].cyc - obs_q[i-1].cyc);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    for (int k = 0; k < 3; k++) begin drive(1, 30); drive(0, 70); end
    drive(1, 30); drive(0, 20);
    @(negedge sys_clk);
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    n_checks++;
    if (period !== '0 || high_time !== '0 || meas_valid !== 1'b0 || timeout !== 1'b0)
      $display("FAIL midrst_zero got per=%0d hi=%0d mv=%b to=%b want all 0", period, high_time, meas_valid, timeout);
    else n_pass++;
    rst = 1'b0;
    model_clear();
    drive(0, 30);
    for (int k = 0; k < 3; k++) begin drive(1, 30); drive(0, 70); end
    drive(1, 30); drive(0, 20);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].to !== exp_q[i].to || obs_q[i].per !== exp_q[i].per || obs_q[i].hi !== exp_q[i].hi)
        $display("FAIL midrst_ev%0d got to=%b per=%0d hi=%0d want to=%b per=%0d hi=%0d", i,
                 obs_q[i].to, obs_q[i].per, obs_q[i].hi, exp_q[i].to, exp_q[i].per, exp_q[i].hi);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int rise_cyc;
    int n_to;
    reset_dut();
    drive(1, 30); drive(0, 70);
    rise_cyc = cyc;
    drive(1, 700);
    drive(0, 50);
    for (int k = 0; k < 2; k++) begin drive(1, 30); drive(0, 70); end
    drive(1, 30); drive(0, 20);
    n_to = 0;
    foreach (obs_q[i]) if (obs_q[i].to) begin
      n_to++;
      n_checks++;
      if (obs_q[i].cyc - rise_cyc < TO || obs_q[i].cyc - rise_cyc > TO + 10)
        $display("FAIL timeout_delay got %0d want %0d..%0d", obs_q[i].cyc - rise_cyc, TO, TO + 10);
      else n_pass++;
    end
    n_checks++;
    if (n_to !== 1) $display("FAIL timeout_pulses got %0d want 1", n_to); else n_pass++;
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL timeout_count got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].to !== exp_q[i].to || obs_q[i].per !== exp_q[i].per ||
          obs_q[i].hi !== exp_q[i].hi || obs_q[i].lvl !== exp_q[i].lvl)
        $display("FAIL timeout_ev%0d got to=%b per=%0d hi=%0d lvl=%b want to=%b per=%0d hi=%0d lvl=%b", i,
                 obs_q[i].to, obs_q[i].per, obs_q[i].hi, obs_q[i].lvl,
                 exp_q[i].to, exp_q[i].per, exp_q[i].hi, exp_q[i].lvl);
      else n_pass++;
    end
  endtask

  task automatic test_coincident();
    reset_dut();
    drive(1, 30); drive(0, TO - 30);
    drive(1, 30); drive(0, TO - 29);
    drive(1, 30); drive(0, 20);
    n_checks++;
    if (obs_q.size() < 1 || obs_q[0].to !== 1'b0 || obs_q[0].per !== CW'(TO))
      $display("FAIL coincident_pub got n=%0d want meas per=%0d", obs_q.size(), TO);
    else n_pass++;
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL coincident_count got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].to !== exp_q[i].to || obs_q[i].per !== exp_q[i].per ||
          obs_q[i].hi !== exp_q[i].hi || obs_q[i].lvl !== exp_q[i].lvl)
        $display("FAIL coincident_ev%0d got to=%b per=%0d hi=%0d lvl=%b want to=%b per=%0d hi=%0d lvl=%b", i,
                 obs_q[i].to, obs_q[i].per, obs_q[i].hi, obs_q[i].lvl,
                 exp_q[i].to, exp_q[i].per, exp_q[i].hi, exp_q[i].lvl);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      drive(1, 30); drive(0, 30); drive(1, 1, GLITCH_VIS); drive(0, 39);
    end
    drive(1, 30); drive(0, 20);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL glitch_count got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].to !== exp_q[i].to || obs_q[i].per !== exp_q[i].per || obs_q[i].hi !== exp_q[i].hi)
        $display("FAIL glitch_ev%0d got to=%b per=%0d hi=%0d want to=%b per=%0d hi=%0d", i,
                 obs_q[i].to, obs_q[i].per, obs_q[i].hi, exp_q[i].to, exp_q[i].per, exp_q[i].hi);
      else n_pass++;
    end
  endtask

  task automatic test_duty_sweep();
    reset_dut();
    for (int h = HMIN; h <= HMAX; h++) begin drive(1, h); drive(0, 100 - h); end
    drive(1, 30); drive(0, 20);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL sweep_count got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].to !== exp_q[i].to || obs_q[i].per !== exp_q[i].per || obs_q[i].hi !== exp_q[i].hi)
        $display("FAIL sweep_ev%0d got to=%b per=%0d hi=%0d want to=%b per=%0d hi=%0d", i,
                 obs_q[i].to, obs_q[i].per, obs_q[i].hi, exp_q[i].to, exp_q[i].per, exp_q[i].hi);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int r;
    reset_dut();
    both_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      r = int'($urandom_range(0, 5));
      if (r == 0) begin
        drive(1, int'($urandom_range(TO + 20, TO + 100))); drive(0, int'($urandom_range(2, 100)));
      end else if (r == 1) begin
        drive(1, int'($urandom_range(2, 150))); drive(0, int'($urandom_range(TO + 20, TO + 100)));
      end else begin
        drive(1, int'($urandom_range(2, 200))); drive(0, int'($urandom_range(2, 200)));
      end
    end
    drive(1, 30); drive(0, 20);
    n_checks++;
    if (both_cnt !== 0) $display("FAIL random_overlap got %0d want 0", both_cnt); else n_pass++;
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL random_count got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i].to !== exp_q[i].to || obs_q[i].per !== exp_q[i].per ||
          obs_q[i].hi !== exp_q[i].hi || obs_q[i].lvl !== exp_q[i].lvl)
        $display("FAIL random_ev%0d got to=%b per=%0d hi=%0d lvl=%b want to=%b per=%0d hi=%0d lvl=%b", i,
                 obs_q[i].to, obs_q[i].per, obs_q[i].hi, obs_q[i].lvl,
                 exp_q[i].to, exp_q[i].per, exp_q[i].hi, exp_q[i].lvl);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fixed_pwm();
    test_reset_mid();
    test_timeout();
    test_coincident();
    test_glitch();
    test_duty_sweep();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
